// File: rtl/shift_cmd_scheduler_pkg.sv
// Shared definitions for the shift command scheduler.
// - Operation and direction encodings understood by the barrel shifter.
// - The 14-bit queued command layout {data, op, dir, amount}.
// - The scheduler state enum.
package shift_cmd_scheduler_pkg;

  localparam logic [1:0] OP_STORE  = 2'd0;
  localparam logic [1:0] OP_ROTATE = 2'd1;
  localparam logic [1:0] OP_LSHIFT = 2'd2;
  localparam logic [1:0] OP_ASHIFT = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned CmdWidth = 14;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] op;
    logic       dir;
    logic [2:0] amount;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StOut
  } state_e;

  function automatic cmd_entry_t pack_cmd(input logic [7:0] data, input logic [1:0] op,
                                          input logic dir, input logic [2:0] amount);
    cmd_entry_t e;
    e.data   = data;
    e.op     = op;
    e.dir    = dir;
    e.amount = amount;
    return e;
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous FIFO holding queued shift commands.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push_i    - write wdata_i (ignored when full)
//   pop_i     - drop the head entry (ignored when empty)
//   wdata_i   - entry to write
//   rdata_o   - current head entry (valid when !empty_o)
//   full_o    - DEPTH entries held
//   empty_o   - no entries held
//   count_o   - occupancy, 0..DEPTH
module shift_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned Width = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [Width-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/shift_cmd_scheduler.sv
// Command front-end for three_function_barrel_shifter.
// Queues shift commands, issues them one at a time to the shifter's registered inputs,
// waits out the shifter register stage, captures the result and offers it downstream
// on a valid/ready interface. Results leave in command order, at most one per 3 cycles.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_valid/cmd_ready       - command handshake (cmd_ready = FIFO not full)
//   cmd_data/op/dir/amount    - command fields
//   sh_*                      - registered drive to the shifter inputs
//   sh_out_data               - shifter result
//   res_valid/res_ready       - result handshake
//   res_data/res_op           - captured result and the op that produced it
//   cmd_count                 - FIFO occupancy
module shift_cmd_scheduler
  import shift_cmd_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_data,
  input  logic [1:0]                 cmd_op,
  input  logic                       cmd_dir,
  input  logic [2:0]                 cmd_amount,
  output logic [7:0]                 sh_in_data,
  output logic [1:0]                 sh_operation,
  output logic                       sh_direction,
  output logic [2:0]                 sh_number_of_positions,
  input  logic [7:0]                 sh_out_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_data,
  output logic [1:0]                 res_op,
  output logic [$clog2(DEPTH+1)-1:0] cmd_count
);

  state_e              state_q, state_d;
  cmd_entry_t          sh_q, sh_d;
  logic                res_valid_q, res_valid_d;
  logic [7:0]          res_data_q, res_data_d;
  logic [1:0]          res_op_q, res_op_d;

  cmd_entry_t          cmd_in;
  cmd_entry_t          fifo_head;
  logic [CmdWidth-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic                fifo_push, fifo_pop;

  assign cmd_in    = pack_cmd(cmd_data, cmd_op, cmd_dir, cmd_amount);
  assign fifo_head = fifo_rdata;
  // No bypass: a pop in the same cycle does not open the FIFO when full.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .Width (CmdWidth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (cmd_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (cmd_count)
  );

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    fifo_pop    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          sh_d     = fifo_head;
          fifo_pop = 1'b1;
          state_d  = StIssue;
        end
      end
      // Shifter captures sh_* on this edge.
      StIssue: state_d = StWait;
      // sh_q.op still names the in-flight command; sh_* only change on load edges.
      StWait: begin
        res_data_d  = sh_out_data;
        res_op_d    = sh_q.op;
        res_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            sh_d     = fifo_head;
            fifo_pop = 1'b1;
            state_d  = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= OP_STORE;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
    end
  end

  assign sh_in_data             = sh_q.data;
  assign sh_operation           = sh_q.op;
  assign sh_direction           = sh_q.dir;
  assign sh_number_of_positions = sh_q.amount;
  assign res_valid              = res_valid_q;
  assign res_data               = res_data_q;
  assign res_op                 = res_op_q;

endmodule

// File: tb/tb_shift_cmd_scheduler.sv
// Directed bench for shift_cmd_scheduler driving a behavioural barrel shifter
// (registered inputs, combinational result). Expected results are hand-computed.
module tb_shift_cmd_scheduler;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [2:0] cmd_amount;
  logic [7:0] sh_in_data;
  logic [1:0] sh_operation;
  logic       sh_direction;
  logic [2:0] sh_number_of_positions;
  logic [7:0] sh_out_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_op;
  logic [$clog2(DEPTH+1)-1:0] cmd_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_cmd_scheduler #(
    .DEPTH (DEPTH)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_data               (cmd_data),
    .cmd_op                 (cmd_op),
    .cmd_dir                (cmd_dir),
    .cmd_amount             (cmd_amount),
    .sh_in_data             (sh_in_data),
    .sh_operation           (sh_operation),
    .sh_direction           (sh_direction),
    .sh_number_of_positions (sh_number_of_positions),
    .sh_out_data            (sh_out_data),
    .res_valid              (res_valid),
    .res_ready              (res_ready),
    .res_data               (res_data),
    .res_op                 (res_op),
    .cmd_count              (cmd_count)
  );

  // Behavioural three_function_barrel_shifter.
  logic [7:0] shf_data_q;
  logic [1:0] shf_op_q;
  logic       shf_dir_q;
  logic [2:0] shf_amt_q;

  always @(posedge clk) begin
    shf_data_q <= sh_in_data;
    shf_op_q   <= sh_operation;
    shf_dir_q  <= sh_direction;
    shf_amt_q  <= sh_number_of_positions;
  end

  function automatic logic [7:0] shift_fn(input logic [7:0] d, input logic [1:0] op,
                                          input logic dir, input logic [2:0] n);
    logic [15:0] dd;
    dd = {d, d};
    case (op)
      2'd0: return d;
      2'd1: begin
        if (dir) begin
          dd = dd >> n;
          return dd[7:0];
        end else begin
          dd = dd << n;
          return dd[15:8];
        end
      end
      2'd2: return dir ? (d >> n) : (d << n);
      default: return dir ? 8'($signed(d) >>> n) : (d << n);
    endcase
  endfunction

  always_comb sh_out_data = shift_fn(shf_data_q, shf_op_q, shf_dir_q, shf_amt_q);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d, input logic [1:0] op, input logic dir,
                       input logic [2:0] n, output bit accepted);
    cmd_valid  = 1'b1;
    cmd_data   = d;
    cmd_op     = op;
    cmd_dir    = dir;
    cmd_amount = n;
    accepted   = cmd_ready;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] exp_data,
                               input logic [1:0] exp_op);
    int waited = 0;
    while (!res_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data), 32'(exp_data));
    check({tag, "_op"}, 32'(res_op), 32'(exp_op));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;
    int seen;

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_op     = '0;
    cmd_dir    = 1'b0;
    cmd_amount = '0;
    res_ready  = 1'b0;

    // 1. Reset.
    tick();
    tick();
    rst = 1'b0;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    check("rst_sh_operation", 32'(sh_operation), 32'd0);
    check("rst_sh_in_data", 32'(sh_in_data), 32'd0);

    // 2. Single command latency: rotl(0xB4, 3) = 0xA5.
    res_ready = 1'b1;
    offer(8'hB4, 2'd1, 1'b0, 3'd3, acc);
    check("lat_accept", 32'(acc), 32'd1);
    check("lat_count_a", 32'(cmd_count), 32'd1);
    tick();
    check("lat_valid_a1", 32'(res_valid), 32'd0);
    check("lat_sh_data", 32'(sh_in_data), 32'hB4);
    check("lat_sh_op", 32'(sh_operation), 32'd1);
    check("lat_sh_amt", 32'(sh_number_of_positions), 32'd3);
    check("lat_count_a1", 32'(cmd_count), 32'd0);
    tick();
    check("lat_valid_a2", 32'(res_valid), 32'd0);
    tick();
    check("lat_valid_a3", 32'(res_valid), 32'd1);
    check("lat_data", 32'(res_data), 32'hA5);
    check("lat_op", 32'(res_op), 32'd1);
    tick();
    check("lat_valid_a4", 32'(res_valid), 32'd0);

    // 3. Backpressure fill: 6 offered, 5 accepted, then drained in order.
    res_ready = 1'b0;
    n_acc = 0;
    offer(8'h01, 2'd2, 1'b0, 3'd1, acc); n_acc += int'(acc);
    offer(8'h81, 2'd1, 1'b1, 3'd1, acc); n_acc += int'(acc);
    offer(8'h80, 2'd3, 1'b1, 3'd3, acc); n_acc += int'(acc);
    offer(8'h0F, 2'd2, 1'b1, 3'd2, acc); n_acc += int'(acc);
    offer(8'h66, 2'd0, 1'b0, 3'd5, acc); n_acc += int'(acc);
    check("fill_ready_full", 32'(cmd_ready), 32'd0);
    check("fill_count_full", 32'(cmd_count), 32'd4);
    offer(8'hEE, 2'd0, 1'b0, 3'd0, acc); n_acc += int'(acc);
    check("fill_accepted", 32'(n_acc), 32'd5);
    res_ready = 1'b1;
    expect_result("drain0", 8'h02, 2'd2);
    expect_result("drain1", 8'hC0, 2'd1);
    expect_result("drain2", 8'hF0, 2'd3);
    expect_result("drain3", 8'h03, 2'd2);
    expect_result("drain4", 8'h66, 2'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) seen++;
      tick();
    end
    check("drain_no_extra", 32'(seen), 32'd0);
    check("drain_count", 32'(cmd_count), 32'd0);

    // 4. Hold stability under backpressure, then 2-cycle release of next result.
    res_ready = 1'b0;
    offer(8'hC3, 2'd1, 1'b0, 3'd4, acc);
    offer(8'h40, 2'd3, 1'b0, 3'd1, acc);
    seen = 0;
    while (!res_valid && seen < 20) begin
      tick();
      seen++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'h3C);
      check("hold_op", 32'(res_op), 32'd1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("rel_valid_h", 32'(res_valid), 32'd0);
    tick();
    check("rel_valid_h1", 32'(res_valid), 32'd0);
    tick();
    check("rel_valid_h2", 32'(res_valid), 32'd1);
    check("rel_data", 32'(res_data), 32'h80);
    check("rel_op", 32'(res_op), 32'd3);
    tick();

    // 5. Logic shift right then store.
    offer(8'h90, 2'd2, 1'b1, 3'd2, acc);
    offer(8'h5A, 2'd0, 1'b0, 3'd0, acc);
    expect_result("lsr", 8'h24, 2'd2);
    expect_result("store", 8'h5A, 2'd0);
    for (int i = 0; i < 4; i++) tick();

    // 6. Reset in WAIT with two commands queued.
    res_ready = 1'b0;
    offer(8'hAA, 2'd0, 1'b0, 3'd0, acc);
    offer(8'hBB, 2'd0, 1'b0, 3'd0, acc);
    offer(8'hCC, 2'd0, 1'b0, 3'd0, acc);
    check("mid_count_wait", 32'(cmd_count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_count", 32'(cmd_count), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) seen++;
      tick();
    end
    check("mid_no_stale", 32'(seen), 32'd0);
    offer(8'h11, 2'd2, 1'b0, 3'd3, acc);
    expect_result("post_rst", 8'h88, 2'd2);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) seen++;
      tick();
    end
    check("post_rst_only_one", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
